// File: rtl/pong_pkg.sv
// Pong game controller shared definitions: FSM states
// plus display geometry also used by the VGA datapath.
package pong_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SERVE,
      ST_PLAY,
      ST_OVER
   } state_e;

   localparam int H_VISIBLE  = 640;
   localparam int V_VISIBLE  = 480;
   localparam int PADDLE_W   = 8;
   localparam int PADDLE_H   = 64;
   localparam int PADDLE_L_X = 16;
   localparam int PADDLE_R_X = H_VISIBLE - PADDLE_L_X - PADDLE_W;
   localparam int PADDLE_Y0  = (V_VISIBLE - PADDLE_H) / 2;

endpackage

// File: rtl/pong_score.sv
// Per-player score counter: saturates at WIN_SCORE,
// synchronous clear, flags for "at win" and "next point wins".
module pong_score
   import pong_pkg::*;
#(
   parameter int WIN_SCORE = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] score,
   output logic       at_win,
   output logic       win_on_inc
);

   localparam logic [3:0] WIN = 4'(WIN_SCORE);

   logic [3:0] score_q;
   logic [3:0] score_d;

   always_comb begin
      score_d = score_q;
      if (clr) begin
         score_d = '0;
      end else if (inc && (score_q != WIN)) begin
         score_d = score_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         score_q <= '0;
      end else begin
         score_q <= score_d;
      end
   end

   assign score      = score_q;
   assign at_win     = (score_q == WIN);
   assign win_on_inc = (score_q == (WIN - 4'd1));

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencing: start detection, serve hold-off,
// scoring and game-over, all outputs registered.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int SERVE_FRAMES = 60,
   parameter int WIN_SCORE    = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       start_btn,
   input  logic       miss_l,
   input  logic       miss_r,
   output logic       ball_run,
   output logic       serve_load,
   output logic       serve_side,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic       game_over,
   output logic       winner
);

   localparam logic [7:0] SERVE_CNT = 8'(SERVE_FRAMES);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       btn_q, btn_d;
   logic       side_q, side_d;
   logic       winner_q, winner_d;
   logic       run_q, load_q, over_q;

   logic start;
   logic clr;
   logic load;
   logic inc_l, inc_r;
   logic l_at_win, r_at_win;
   logic l_win_inc, r_win_inc;

   pong_score #(.WIN_SCORE(WIN_SCORE)) u_score_l (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .inc        (inc_l),
      .score      (score_l),
      .at_win     (l_at_win),
      .win_on_inc (l_win_inc)
   );

   pong_score #(.WIN_SCORE(WIN_SCORE)) u_score_r (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .inc        (inc_r),
      .score      (score_r),
      .at_win     (r_at_win),
      .win_on_inc (r_win_inc)
   );

   // Button is only looked at on frame boundaries.
   assign start = frame_tick & start_btn & ~btn_q;
   assign btn_d = frame_tick ? start_btn : btn_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      side_d   = side_q;
      winner_d = winner_q;
      clr      = 1'b0;
      load     = 1'b0;
      inc_l    = 1'b0;
      inc_r    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               clr     = 1'b1;
               load    = 1'b1;
               state_d = ST_SERVE;
            end
         end
         ST_SERVE: begin
            if (frame_tick) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == SERVE_CNT) begin
                  state_d = ST_PLAY;
               end
            end
         end
         ST_PLAY: begin
            if (miss_l) begin
               inc_r  = ~r_at_win;
               side_d = 1'b1;
               if (r_win_inc) begin
                  winner_d = 1'b1;
                  state_d  = ST_OVER;
               end else begin
                  load    = 1'b1;
                  state_d = ST_SERVE;
               end
            end else if (miss_r) begin
               inc_l  = ~l_at_win;
               side_d = 1'b0;
               if (l_win_inc) begin
                  winner_d = 1'b0;
                  state_d  = ST_OVER;
               end else begin
                  load    = 1'b1;
                  state_d = ST_SERVE;
               end
            end
         end
         ST_OVER: begin
            if (start) begin
               clr     = 1'b1;
               load    = 1'b1;
               side_d  = ~winner_q;
               state_d = ST_SERVE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (load) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         btn_q    <= 1'b1;
         side_q   <= 1'b1;
         winner_q <= 1'b0;
         run_q    <= 1'b0;
         load_q   <= 1'b0;
         over_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         btn_q    <= btn_d;
         side_q   <= side_d;
         winner_q <= winner_d;
         run_q    <= (state_d == ST_PLAY);
         load_q   <= load;
         over_q   <= (state_d == ST_OVER);
      end
   end

   assign ball_run   = run_q;
   assign serve_load = load_q;
   assign serve_side = side_q;
   assign game_over  = over_q;
   assign winner     = winner_q;

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter SERVE_FRAMES, default 60: serve hold-off in frames; legal range 1..255.
REQ-002 Parameter WIN_SCORE, default 9: points that end a game; legal range 1..15.
REQ-003 clk  input  1  pixel clock (25.175 MHz); the only clock.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 frame_tick  input  1  one-cycle pulse per frame, issued at start of vertical blank.
REQ-006 start_btn  input  1  start/restart button level; already synchronised to clk.
REQ-007 miss_l  input  1  one-cycle pulse: ball passed left paddle (right player scores).
REQ-008 miss_r  input  1  one-cycle pulse: ball passed right paddle (left player scores).
REQ-009 ball_run  output  1  ball motion enable; high only in PLAY.
REQ-010 serve_load  output  1  one-cycle pulse: reposition ball at the serving paddle.
REQ-011 serve_side  output  1  serving paddle; 0 = left, 1 = right.
REQ-012 score_l  output  4  left score, binary.
REQ-013 score_r  output  4  right score, binary.
REQ-014 game_over  output  1  high in OVER.
REQ-015 winner  output  1  valid while game_over is high; 0 = left, 1 = right.

Function
REQ-016 States SHALL be IDLE, SERVE, PLAY, OVER; all outputs SHALL be registered and change 1 cycle after the causing input.
REQ-017 start_btn SHALL be sampled only on frame_tick cycles; a "start" SHALL be a 0-then-1 transition between two consecutive samples.
REQ-018 IDLE to SERVE on start; scores SHALL be cleared on this transition.
REQ-019 On every SERVE entry, serve_load SHALL pulse for exactly one cycle.
REQ-020 On every SERVE entry, the frame counter (8-bit) SHALL be cleared.
REQ-021 In SERVE, the frame counter SHALL increment per frame_tick.
REQ-022 SERVE to PLAY on the frame_tick that brings the frame counter to SERVE_FRAMES.
REQ-023 In PLAY, miss_l SHALL increment score_r and set serve_side=1.
REQ-024 In PLAY, miss_r SHALL increment score_l and set serve_side=0.
REQ-025 After a miss in PLAY, next state SHALL be OVER if the new score equals WIN_SCORE, else SERVE.
REQ-026 If miss_l and miss_r are asserted in the same cycle, miss_l SHALL win and miss_r SHALL be dropped.
REQ-027 miss_l/miss_r outside PLAY SHALL be ignored; scores SHALL never exceed WIN_SCORE.
REQ-028 On entering OVER, winner SHALL be set to the scoring side; scores SHALL hold.
REQ-029 OVER to SERVE on start; scores SHALL clear; serve_side SHALL be set to the loser.
REQ-030 frame_tick coincident with a miss SHALL NOT advance the serve counter of the new SERVE visit.

Reset
REQ-031 On rst: state=IDLE, score_l=score_r=0, serve_side=1, winner=0, frame counter=0, start sample=1 (no spurious start), all pulse/level outputs 0.
REQ-032 rst asserted in any state SHALL take effect on the next clk edge and abort any pending serve_load.

Structure
REQ-033 A shared package (pong_pkg) SHALL hold the state enumeration and the display constants (visible area, paddle size and positions) also used by the VGA datapath.
REQ-034 One sub-module, pong_score, SHALL hold the per-player saturating score counter (increment, clear, at-win flag) and be instantiated twice.

Verification
REQ-035 rst; start_btn 0 then 1 across two frame_ticks -> serve_load pulse, serve_side=1, ball_run rises exactly 60 frame_ticks later.
REQ-036 PLAY, miss_l pulse -> score_r=1, serve_side=1, ball_run=0 next cycle, serve_load pulse, PLAY resumes after 60 frame_ticks.
REQ-037 miss_l and miss_r in the same cycle -> score_r+1, score_l unchanged, serve_side=1.
REQ-038 Nine miss_r events (WIN_SCORE=9) -> score_l=9, game_over=1, winner=0; further misses leave scores unchanged.
REQ-039 start_btn held high throughout -> no start; from OVER, release then press -> scores 0, serve_side=1 (loser right).
REQ-040 rst mid-SERVE (frame counter 30) -> IDLE, scores 0, no ball_run or serve_load afterwards until a new start.
